dp_rr_scheduler: RTL and testbench



---
 rtl/dp_pkg.sv | 19 +
 rtl/dp_rr_arbiter.sv | 32 +++
 rtl/dp_rr_scheduler.sv | 117 +++++++++++
 tb/tb_dp_rr_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the round-robin datapath scheduler: datapath widths,
// scheduler FSM state type and datapath opcode encodings.
package dp_pkg;

  localparam int DP_W   = 16;
  localparam int DP_OPW = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} dp_sched_state_t;

  localparam logic [DP_OPW-1:0] OP_ADD   = 3'd0;
  localparam logic [DP_OPW-1:0] OP_ADDC  = 3'd1;
  localparam logic [DP_OPW-1:0] OP_SUBB  = 3'd2;
  localparam logic [DP_OPW-1:0] OP_SUB   = 3'd3;
  localparam logic [DP_OPW-1:0] OP_PASS  = 3'd4;
  localparam logic [DP_OPW-1:0] OP_INC   = 3'd5;
  localparam logic [DP_OPW-1:0] OP_DEC   = 3'd6;
  localparam logic [DP_OPW-1:0] OP_PASS2 = 3'd7;

endpackage

// File: rtl/dp_rr_arbiter.sv
// Combinational round-robin winner select: first requester at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any_req
);

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dp_rr_scheduler.sv
// Round-robin scheduler sharing one combinational datapath among NREQ requesters.
// Optional per-requester grant counters under DP_RR_SCHEDULER_STATS_EN.
module dp_rr_scheduler
  import dp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DP_W,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W-1:0]      req_a,
  input  logic [NREQ*W-1:0]      req_b,
  input  logic [NREQ*DP_OPW-1:0] req_opcode,
  output logic [W-1:0]           dp_a,
  output logic [W-1:0]           dp_b,
  output logic [DP_OPW-1:0]      dp_opcode,
  input  logic [W-1:0]           dp_y,
  input  logic                   dp_co,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W-1:0]           rsp_y,
  output logic                   rsp_co,
  output logic [IDW-1:0]         rsp_id
`ifdef DP_RR_SCHEDULER_STATS_EN
  ,
  output logic [NREQ*16-1:0]     grant_cnt
`endif
);

  dp_sched_state_t state, state_nxt;
  logic [IDW-1:0]  rr_ptr, ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            any_req;
  logic            hs;

  logic [NREQ-1:0][W-1:0]      a_arr, b_arr;
  logic [NREQ-1:0][DP_OPW-1:0] op_arr;

  assign a_arr  = req_a;
  assign b_arr  = req_b;
  assign op_arr = req_opcode;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  // Ready is gated by reset so no handshake can land on a reset edge.
  assign hs        = (state == IDLE) && any_req && rst_n;
  assign req_ready = hs ? grant : '0;
  assign ptr_nxt   = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_opcode <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_co    <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (hs) begin
        dp_a      <= a_arr[win_idx];
        dp_b      <= b_arr[win_idx];
        dp_opcode <= op_arr[win_idx];
        rsp_id    <= win_idx;
        rr_ptr    <= ptr_nxt;
      end
      if (state == EXEC) begin
        rsp_y     <= dp_y;
        rsp_co    <= dp_co;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef DP_RR_SCHEDULER_STATS_EN
  logic [NREQ-1:0][15:0] cnt;

  // Saturating so a long-running client never appears to have zero grants.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else begin
      for (int i = 0; i < NREQ; i++)
        if (hs && grant[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Scoreboard bench for dp_rr_scheduler: reference model predicts grants and
// results from the round-robin rules; a separate monitor checks responses.
module tb_dp_rr_scheduler;
  import dp_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid, req_ready;
  logic [NREQ*W-1:0]      req_a, req_b;
  logic [NREQ*DP_OPW-1:0] req_opcode;
  logic [W-1:0]           dp_a, dp_b, dp_y;
  logic [DP_OPW-1:0]      dp_opcode;
  logic                   dp_co;
  logic                   rsp_valid, rsp_ready, rsp_co;
  logic [W-1:0]           rsp_y;
  logic [IDW-1:0]         rsp_id;
`ifdef DP_RR_SCHEDULER_STATS_EN
  logic [NREQ*16-1:0]     grant_cnt;
`endif

  always #5 clk = ~clk;

  dp_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .dp_a(dp_a), .dp_b(dp_b), .dp_opcode(dp_opcode),
    .dp_y(dp_y), .dp_co(dp_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_co(rsp_co), .rsp_id(rsp_id)
`ifdef DP_RR_SCHEDULER_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // Stand-in shared datapath: {co, y} as a 17-bit arithmetic result.
  function automatic logic [16:0] dpf(input logic [15:0] a, input logic [15:0] b,
                                      input logic [2:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_ADDC: return {1'b0, a} + {1'b0, b} + 17'd1;
      OP_SUBB: return {1'b0, a} - {1'b0, b} - 17'd1;
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_PASS: return {1'b0, a};
      OP_INC:  return {1'b0, a} + 17'd1;
      OP_DEC:  return {1'b0, a} - 17'd1;
      default: return {1'b0, b};
    endcase
  endfunction

  always_comb {dp_co, dp_y} = dpf(dp_a, dp_b, dp_opcode);

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   y;
    logic           co;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              free = 1'b1;
  int              ptr  = 0;
  bit              pend = 1'b0;
  int              lat  = 0;
  logic [NREQ-1:0] hs_last = '0;
  logic [W-1:0]    sav_a, sav_b;
  logic [2:0]      sav_op;

  initial begin
    logic [NREQ-1:0] exp_ready;
    int              win;
    int              j;
    logic [16:0]     r;
    exp_t            e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("ready_during_reset", req_ready, 0);
        q.delete();
        free = 1'b1; ptr = 0; pend = 1'b0; hs_last = '0;
      end else begin
        win = -1;
        if (free)
          for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (win < 0 && req_valid[j]) win = j;
          end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        hs_last = req_valid & req_ready;
        if (pend) begin
          lat++;
          if (lat == 1) begin
            chk("exec_no_valid", rsp_valid, 0);
            chk("dp_a", dp_a, sav_a);
            chk("dp_b", dp_b, sav_b);
            chk("dp_opcode", dp_opcode, sav_op);
          end else begin
            chk("rsp_latency", rsp_valid, 1);
            pend = 1'b0;
          end
        end
        if (!free && rsp_valid && rsp_ready) free = 1'b1;
        if (win >= 0) begin
          sav_a  = req_a[win*W +: W];
          sav_b  = req_b[win*W +: W];
          sav_op = req_opcode[win*3 +: 3];
          r      = dpf(sav_a, sav_b, sav_op);
          e.id   = IDW'(win);
          e.y    = r[15:0];
          e.co   = r[16];
          q.push_back(e);
          free = 1'b0;
          ptr  = (win + 1) % NREQ;
          pend = 1'b1;
          lat  = 0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          e = q[0];
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_co", rsp_co, e.co);
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_payload(input int i);
    req_a[i*W +: W]      = W'($urandom);
    req_b[i*W +: W]      = W'($urandom);
    req_opcode[i*3 +: 3] = 3'($urandom_range(0, 7));
  endtask

  // keep_all: every requester stays valid; otherwise random valid and rsp_ready.
  task automatic step(input bit keep_all);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_last[i]) begin
        set_payload(i);
        req_valid[i] = keep_all ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else if (!keep_all && !req_valid[i])
        req_valid[i] = ($urandom_range(0, 3) == 0);
    end
    if (!keep_all) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_opcode[i*3 +: 3] = op;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(posedge clk); #1;
      got = hs_last[i];
    end
    chk("issue_accepted", got, 1);
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_co", rsp_co, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_dp_opcode", dp_opcode, 0);
    rst_n = 1'b1;

    // single request, carry path, subtract
    issue(1, 16'h0003, 16'h0004, OP_ADD);
    issue(0, 16'h8000, 16'h8000, OP_ADD);
    issue(2, 16'h0005, 16'h0003, OP_SUB);
    issue(3, 16'h0000, 16'h0001, OP_SUBB);

    // all requesters continuously valid: strict rotation
    for (int i = 0; i < NREQ; i++) set_payload(i);
    req_valid = '1;
    repeat (20) step(1'b1);

    // back-pressure: hold rsp_ready low for 5 cycles once a response appears
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      step(1'b1);
      seen = rsp_valid;
    end
    chk("bp_rsp_seen", seen, 1);
    rsp_ready = 1'b0;
    repeat (5) step(1'b1);
    rsp_ready = 1'b1;
    repeat (6) step(1'b1);

    // reset in EXEC: operation dropped, pointer back to 0
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      step(1'b1);
      seen = (hs_last != '0);
    end
    chk("exec_reached", seen, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_dp_a", dp_a, 0);
    rst_n = 1'b1;
    repeat (8) step(1'b1);

    // randomized traffic and back-pressure
    req_valid = '0;
    repeat (400) step(1'b0);
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;

`ifdef DP_RR_SCHEDULER_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) issue(2, 16'(k), 16'h1, OP_ADD);
    for (int i = 0; i < NREQ; i++)
      chk("grant_cnt", grant_cnt[i*16 +: 16], (i == 2) ? 32'd3 : 32'd0);
    force dut.cnt = 64'h0000_FFFF_0000_0000;
    #1;
    release dut.cnt;
    issue(2, 16'h1, 16'h1, OP_ADD);
    chk("grant_cnt_sat", grant_cnt[2*16 +: 16], 32'hFFFF);
`endif

    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
